// File: rtl/div_pkg.sv
// div_pkg: shared width defaults and FSM state constants for the restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W = $clog2(DIV_WIDTH);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/div_if.sv
// div_if: request/result handshake bundle between a divider client and div_sequencer.
interface div_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               busy;
  logic               result_valid;
  logic               result_ready;
  logic [2*WIDTH-1:0] result;
  logic               div_by_zero;
  modport master (
    output start, is_signed, dividend, divisor, result_ready,
    input  busy, result_valid, result, div_by_zero
  );
  modport slave (
    input  start, is_signed, dividend, divisor, result_ready,
    output busy, result_valid, result, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on a {rem,quo} pair.
module div_step import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;
  always_comb begin
    sh    = {rem_i, quo_i[WIDTH-1]};
    diff  = {1'b0, sh} - {2'b00, divisor_i};
    rem_o = diff[WIDTH+1] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH+1]};
  end
endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed/unsigned restoring divider with valid/ready result handshake.
module div_sequencer import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic clk,
  input logic reset_n,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [2:0]         state_q, state_d;
  logic               valid_q, dbz_q, hs;
  logic [2*WIDTH-1:0] result_q;
  logic [WIDTH-1:0]   a_q, b_q, rem_q, quo_q, dvs_q, rem_nx, quo_nx, a_mag, b_mag;
  logic               signed_q, qneg_q, rneg_q, zero_q;
  logic [CW-1:0]      cnt_q;
  assign hs    = valid_q & bus.result_ready;
  assign a_mag = (signed_q & a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag = (signed_q & b_q[WIDTH-1]) ? -b_q : b_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start ? S_PREP : S_IDLE;
      S_PREP:  state_d = (b_q == '0) ? S_DONE : S_ITER;
      S_ITER:  state_d = (cnt_q == '0) ? S_FIX : S_ITER;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = hs ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // Result is captured on the first DONE cycle and only then flagged valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == S_DONE) & ~hs;
      if (state_q == S_DONE && !valid_q) begin
        result_q <= {rem_q, quo_q};
        dbz_q    <= zero_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (bus.start) begin
        a_q      <= bus.dividend;
        b_q      <= bus.divisor;
        signed_q <= bus.is_signed;
      end
      S_PREP: begin
        zero_q <= (b_q == '0);
        rem_q  <= (b_q == '0) ? a_q : '0;
        quo_q  <= (b_q == '0) ? '1 : a_mag;
        dvs_q  <= b_mag;
        qneg_q <= signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        rneg_q <= signed_q & a_q[WIDTH-1];
        cnt_q  <= CW'(WIDTH - 1);
      end
      S_ITER: begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - 1'b1;
      end
      S_FIX: begin
        quo_q <= qneg_q ? -quo_q : quo_q;
        rem_q <= rneg_q ? -rem_q : rem_q;
      end
      default: ;
    endcase
  end
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .quo_i(quo_q), .divisor_i(dvs_q), .rem_o(rem_nx), .quo_o(quo_nx)
  );
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.div_by_zero  = dbz_q;
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized and directed checks of div_sequencer against an arithmetic reference model.
module tb_div_sequencer;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset_n;
  int n_tests = 0;
  int n_fail = 0;
  div_if #(.WIDTH(W)) bus();
  div_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
    longint sa, sb, q, r;
    logic [W-1:0] uq, ur;
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      uq = q[W-1:0];
      ur = r[W-1:0];
    end else begin
      uq = a / b;
      ur = a % b;
    end
    return {1'b0, ur, uq};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Transaction-level model: idle/busy/valid plus the arithmetic result, timed from acceptance.
  int unsigned e = 0;
  int unsigned due = 0;
  bit m_busy = 0;
  bit m_valid = 0;
  logic [2*W:0] m_exp = '0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy  = 0;
      m_valid = 0;
    end else begin
      e++;
      if (m_valid && bus.result_ready) begin
        m_busy  = 0;
        m_valid = 0;
      end else if (!m_busy && bus.start) begin
        m_busy = 1;
        due    = e + ((bus.divisor == 0) ? 2 : W + 3);
        m_exp  = ref_div(bus.dividend, bus.divisor, bus.is_signed);
      end
      if (m_busy && !m_valid && e >= due) m_valid = 1;
    end
  end
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      chk("busy", 64'(bus.busy), 64'(m_busy));
      chk("result_valid", 64'(bus.result_valid), 64'(m_valid));
      if (m_valid) begin
        chk("result", bus.result, m_exp[2*W-1:0]);
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(m_exp[2*W]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s, input int hold,
                       input bit lit, input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz);
    int unsigned n;
    int k;
    bus.start = 1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
    tick();
    n = e;
    bus.start = 0;
    k = 0;
    while (!bus.result_valid && k < 100) begin
      bus.result_ready = 1'($urandom % 2);
      bus.start = ($urandom % 3 == 0);
      bus.dividend = $urandom; bus.divisor = $urandom; bus.is_signed = 1'($urandom % 2);
      tick();
      k++;
    end
    chk("latency", 64'(e - n), (b == 0) ? 64'd2 : 64'(W + 3));
    if (lit) begin
      chk("quotient", 64'(bus.result[W-1:0]), 64'(eq));
      chk("remainder", 64'(bus.result[2*W-1:W]), 64'(er));
      chk("dbz_flag", 64'(bus.div_by_zero), 64'(edz));
    end
    repeat (hold) begin
      bus.result_ready = 0;
      bus.start = 1'($urandom % 2);
      bus.dividend = $urandom; bus.divisor = $urandom % 5;
      tick();
    end
    bus.result_ready = 1;
    bus.start = 1'($urandom % 2);
    tick();
    bus.result_ready = 0;
    bus.start = 0;
    chk("idle_after_handshake", 64'(bus.busy), 64'd0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
    $fatal(1);
  end
  initial begin
    logic [W-1:0] a, b;
    reset_n = 0;
    bus.start = 0; bus.is_signed = 0; bus.dividend = '0; bus.divisor = '0; bus.result_ready = 0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.result_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    #22 reset_n = 1;
    tick();
    do_op(32'd100, 32'd7, 0, 0, 1, 32'd14, 32'd2, 0);
    do_op(32'hFFFFFF9C, 32'd7, 1, 2, 1, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
    do_op(32'd100, 32'hFFFFFFF9, 1, 0, 1, 32'hFFFFFFF2, 32'd2, 0);
    do_op(32'h12345678, 32'd0, 0, 1, 1, 32'hFFFFFFFF, 32'h12345678, 1);
    do_op(32'h80000000, 32'hFFFFFFFF, 1, 0, 1, 32'h80000000, 32'd0, 0);
    do_op(32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 32'd0, 32'h80000000, 0);
    do_op(32'hFFFFFFFB, 32'd0, 1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1);
    do_op(32'd1000, 32'd33, 0, 20, 1, 32'd30, 32'd10, 0);
    bus.start = 1; bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.is_signed = 0;
    tick();
    bus.start = 0;
    repeat (11) tick();
    #2 reset_n = 0;
    #1;
    chk("midop_rst_busy", 64'(bus.busy), 64'd0);
    chk("midop_rst_valid", 64'(bus.result_valid), 64'd0);
    chk("midop_rst_result", bus.result, 64'd0);
    chk("midop_rst_dbz", 64'(bus.div_by_zero), 64'd0);
    tick();
    #2 reset_n = 1;
    tick();
    chk("post_rst_valid", 64'(bus.result_valid), 64'd0);
    do_op(32'd50, 32'd5, 0, 0, 1, 32'd10, 32'd0, 0);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom % 6)
        0: b = '0;
        1: b = $urandom % 16;
        2: b = 32'hFFFFFFFF;
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom >> ($urandom % 32);
      endcase
      do_op(a, b, 1'($urandom % 2), int'($urandom % 4), 0, '0, '0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
REQ-006 dividend  input  WIDTH  numerator; sampled with start.
REQ-007 divisor  input  WIDTH  denominator; sampled with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until the result is consumed.
REQ-009 result_valid  output  1  result on result is valid.
REQ-010 result_ready  input  1  consumer accepts result when high with result_valid.
REQ-011 result  output  2*WIDTH  [2*WIDTH-1:WIDTH] remainder, [WIDTH-1:0] quotient.
REQ-012 div_by_zero  output  1  qualifies result; high when divisor was zero.

Function
REQ-013 FSM states: IDLE, PREP, ITER, FIX, DONE; encoding one-hot or binary, implementer's choice.
REQ-014 IDLE: start=1 registers operands and is_signed and moves to PREP; start=0 stays in IDLE.
REQ-015 PREP: signed mode takes magnitudes of operands, records quotient sign = dividend MSB XOR divisor MSB and remainder sign = dividend MSB; clears the partial remainder, loads the iteration counter with WIDTH-1, moves to ITER; a zero divisor moves directly to DONE instead.
REQ-016 ITER: one restoring step per cycle (shift {rem,quo} left 1, trial-subtract divisor, keep the difference and set quo[0]=1 if non-negative, else restore); the counter decrements and the block moves to FIX after exactly WIDTH steps.
REQ-017 FIX: negates quotient and/or remainder per the recorded signs (signed mode only), moves to DONE.
REQ-018 DONE: result_valid=1 and result held stable; result_valid with result_ready in the same cycle moves to IDLE.
REQ-019 Latency: start accepted at edge N -> result_valid high from edge N+WIDTH+3 (35 for WIDTH=32); divide-by-zero: from edge N+2.
REQ-020 Divide by zero: quotient all ones, remainder = original dividend, div_by_zero=1; div_by_zero is 0 for every other result.
REQ-021 Signed most-negative / -1: quotient = 0x80000000 (wraps), remainder 0, no flag.
REQ-022 start while busy is ignored and does not corrupt the operation in flight.
REQ-023 result_ready without result_valid has no effect; result_valid never drops before handshake.
REQ-024 In the handshake cycle with start=1, start is not accepted; the next request is accepted in IDLE on the following cycle.

Reset
REQ-025 reset_n low forces state IDLE, busy=0, result_valid=0, div_by_zero=0, result=0 immediately, regardless of the clock.
REQ-026 Reset mid-operation (any state) abandons the division; no partial result is ever presented.
REQ-027 Operand and working registers need not be reset but must not reach result before DONE.

Structure
REQ-028 Package div_pkg holds the state enumeration, DIV_WIDTH=32 default, and the iteration-count width constant.
REQ-029 One sub-module, div_step: combinational single restoring iteration (inputs rem, quo, divisor; outputs next rem, next quo), instantiated once inside ITER datapath.
REQ-030 No other sub-modules; the FSM, counter and sign fix-up stay in div_sequencer.

Verification
REQ-031 Unsigned 100/7 -> result_valid at edge N+35, quotient 14, remainder 2, div_by_zero 0.
REQ-032 Signed -100/7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100/-7 -> quotient 0xFFFFFFF2, remainder 2.
REQ-033 Divisor 0, dividend 0x12345678 -> result_valid at N+2, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-035 Pulse reset_n low during ITER cycle 10, then start 50/5 -> no stale result_valid; result quotient 10, remainder 0 at +35.
REQ-036 Hold result_ready=0 for 20 cycles after result_valid while toggling start -> result stable, busy stays 1, no new op accepted until handshake.
